// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared CPU constants for the register file slice
//
// Default widths and architectural register numbers used by the register
// file, its interface and the bench.
package regfile_scoreboard_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_MAX_LD = 4;

    // Hard-wired zero register and the JAL link register.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode-side bus of the register file
//
// Groups the two read ports, the immediate writeback port, load issue,
// load return and the stall/outstanding-count status.
//   master : decode / pipeline side (drives addresses, writes, loads)
//   slave  : register file side (drives read data, stall, ld_cnt)
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = $clog2(DEF_MAX_LD + 1)
);
    logic [ADDR_W-1:0] rs_addr;
    logic              rs_used;
    logic [ADDR_W-1:0] rt_addr;
    logic              rt_used;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_ret_valid;
    logic [ADDR_W-1:0] ld_ret_addr;
    logic [DATA_W-1:0] ld_ret_data;
    logic              stall;
    logic [CNT_W-1:0]  ld_cnt;

    modport master (
        output rs_addr, rs_used, rt_addr, rt_used,
        output wa_en, wa_addr, wa_data,
        output ld_issue, ld_addr,
        output ld_ret_valid, ld_ret_addr, ld_ret_data,
        input  rs_data, rt_data, stall, ld_cnt
    );

    modport slave (
        input  rs_addr, rs_used, rt_addr, rt_used,
        input  wa_en, wa_addr, wa_data,
        input  ld_issue, ld_addr,
        input  ld_ret_valid, ld_ret_addr, ld_ret_data,
        output rs_data, rt_data, stall, ld_cnt
    );

endinterface

// File: rtl/regfile_scoreboard_bypass_mux.sv
// rtl/regfile_scoreboard_bypass_mux.sv - per-read-port forwarding mux
//
// Selects read data for one port: immediate write first, then returning
// load, then the stored array value. With BYPASS=0 only the array is used.
//   arr_data  in   stored register value
//   wa_hit    in   accepted immediate write targets this port's register
//   wa_data   in   immediate write data
//   ret_hit   in   load return targets this port's register
//   ret_data  in   returning load data
//   rd_data   out  selected read data
module regfile_bypass_mux
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BYPASS = 1
) (
    input  logic [DATA_W-1:0] arr_data,
    input  logic              wa_hit,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              ret_hit,
    input  logic [DATA_W-1:0] ret_data,
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = arr_data;
        if (BYPASS != 0) begin
            // Immediate write belongs to the younger instruction, so it wins.
            if (wa_hit) begin
                rd_data = wa_data;
            end else if (ret_hit) begin
                rd_data = ret_data;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - GPR file with load busy scoreboard and stall
//
// Two combinational read ports, an immediate writeback port and a late
// load-return port. Each register carries a busy bit while a load to it is
// outstanding; decode is stalled on reads/writes/issues that would race it.
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high
//   bus    slave side of regfile_scoreboard_if (read, write, load, status)
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1,
    parameter int MAX_LD = DEF_MAX_LD
) (
    input  logic               clock,
    input  logic               reset,
    regfile_scoreboard_if.slave bus
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(MAX_LD + 1);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic [CNT_W-1:0]  ld_cnt;

    logic rs_ret_hit, rt_ret_hit, wa_ret_hit, ld_ret_hit;
    logic rs_hazard, rt_hazard, wa_hazard, ld_hazard, full_hazard;
    logic stall, wa_en_q, ld_issue_q, wa_wr, ld_inc, ld_dec;
    logic rs_wa_hit, rt_wa_hit;

    // A returning load satisfies any consumer of its register this cycle.
    assign rs_ret_hit = bus.ld_ret_valid && (bus.ld_ret_addr == bus.rs_addr) && (bus.rs_addr != ZERO_A);
    assign rt_ret_hit = bus.ld_ret_valid && (bus.ld_ret_addr == bus.rt_addr) && (bus.rt_addr != ZERO_A);
    assign wa_ret_hit = bus.ld_ret_valid && (bus.ld_ret_addr == bus.wa_addr) && (bus.wa_addr != ZERO_A);
    assign ld_ret_hit = bus.ld_ret_valid && (bus.ld_ret_addr == bus.ld_addr) && (bus.ld_addr != ZERO_A);

    // Without forwarding the returning value is not readable yet, so the
    // read hazards cannot be released by a same-cycle return.
    assign rs_hazard   = bus.rs_used && busy[bus.rs_addr] && ((BYPASS == 0) || !rs_ret_hit);
    assign rt_hazard   = bus.rt_used && busy[bus.rt_addr] && ((BYPASS == 0) || !rt_ret_hit);
    assign wa_hazard   = bus.wa_en && busy[bus.wa_addr] && !wa_ret_hit;
    assign ld_hazard   = bus.ld_issue && busy[bus.ld_addr] && !ld_ret_hit;
    assign full_hazard = bus.ld_issue && (ld_cnt == CNT_W'(MAX_LD)) && !bus.ld_ret_valid;

    assign stall      = rs_hazard || rt_hazard || wa_hazard || ld_hazard || full_hazard;
    assign wa_en_q    = bus.wa_en && !stall;
    assign ld_issue_q = bus.ld_issue && !stall;

    assign wa_wr     = wa_en_q && (bus.wa_addr != ZERO_A);
    assign rs_wa_hit = wa_wr && (bus.wa_addr == bus.rs_addr);
    assign rt_wa_hit = wa_wr && (bus.wa_addr == bus.rt_addr);

    // Only loads that were actually tracked count down; r0 is never busy.
    assign ld_inc = ld_issue_q && (bus.ld_addr != ZERO_A);
    assign ld_dec = bus.ld_ret_valid && busy[bus.ld_ret_addr];

    // Set after clear so issue+return to the same register leaves it busy.
    always_comb begin
        busy_next = busy;
        if (bus.ld_ret_valid) begin
            busy_next[bus.ld_ret_addr] = 1'b0;
        end
        if (ld_inc) begin
            busy_next[bus.ld_addr] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy   <= '0;
            ld_cnt <= '0;
        end else begin
            if (bus.ld_ret_valid && (bus.ld_ret_addr != ZERO_A)) begin
                regs[bus.ld_ret_addr] <= bus.ld_ret_data;
            end
            // Later assignment wins: the immediate write is the younger result.
            if (wa_wr) begin
                regs[bus.wa_addr] <= bus.wa_data;
            end
            busy   <= busy_next;
            ld_cnt <= ld_cnt + CNT_W'(ld_inc) - CNT_W'(ld_dec);
        end
    end

    regfile_bypass_mux #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rs_mux (
        .arr_data (regs[bus.rs_addr]),
        .wa_hit   (rs_wa_hit),
        .wa_data  (bus.wa_data),
        .ret_hit  (rs_ret_hit),
        .ret_data (bus.ld_ret_data),
        .rd_data  (bus.rs_data)
    );

    regfile_bypass_mux #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rt_mux (
        .arr_data (regs[bus.rt_addr]),
        .wa_hit   (rt_wa_hit),
        .wa_data  (bus.wa_data),
        .ret_hit  (rt_ret_hit),
        .ret_data (bus.ld_ret_data),
        .rd_data  (bus.rt_data)
    );

    assign bus.stall  = stall;
    assign bus.ld_cnt = ld_cnt;

endmodule
